g2b_rr_arbiter: RTL

//   Shares one Gray-to-binary conversion datapath among N_REQ requesters.

---
 rtl/g2b_pkg.sv | 32 +++
 rtl/g2b_rr_pick.sv | 28 ++
 rtl/g2b_rr_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/g2b_pkg.sv
// Shared types and helpers for the Gray-to-binary round-robin arbiter.
package g2b_pkg;

  localparam int unsigned MAX_W = 64;
  localparam int unsigned CNT_W = 7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } g2b_state_e;

  // Zero-extended input: upper zeros leave the low bits' conversion unchanged.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = '0;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = int'(MAX_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_W-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(MAX_W); i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/g2b_rr_pick.sv
// Rotating-priority picker: first set request after last_grant wins.
module g2b_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin : scan
      int unsigned j;
      j = (32'(last_grant) + k) % N_REQ;
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = ID_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/g2b_rr_arbiter.sv
// Round-robin shared Gray-to-binary converter with one registered output stage.
// Optional per-requester adjacency checker enabled by G2B_ADJ_CHK_EN.
module g2b_rr_arbiter
  import g2b_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_gray,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_binary,
  output logic [$clog2(N_REQ)-1:0] out_id,
  output logic                   out_err
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  g2b_state_e       state, state_n;
  logic [ID_W-1:0]  last_grant, win_idx;
  logic [N_REQ-1:0] grant;
  logic             win_any;
  logic             can_accept_c;
  logic [WIDTH-1:0] sel_gray_c, sel_bin_c;

  // Accept only when the output slot is empty or being drained this cycle.
  assign can_accept_c = !rst && ((state == IDLE) || out_ready);

  g2b_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req       (req_valid & {N_REQ{can_accept_c}}),
    .last_grant(last_grant),
    .grant     (grant),
    .idx       (win_idx),
    .any       (win_any)
  );

  assign req_ready  = grant;
  assign out_valid  = (state == HOLD);
  assign sel_gray_c = req_gray[win_idx*WIDTH +: WIDTH];
  assign sel_bin_c  = WIDTH'(gray2bin(MAX_W'(sel_gray_c)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (win_any)                           state_n = HOLD;
    else if ((state == HOLD) && out_ready) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_binary <= '0;
      out_id     <= '0;
      last_grant <= ID_W'(N_REQ - 1);
    end else if (win_any) begin
      out_binary <= sel_bin_c;
      out_id     <= win_idx;
      last_grant <= win_idx;
    end
  end

`ifdef G2B_ADJ_CHK_EN
  logic [WIDTH-1:0] hist [N_REQ];
  logic [N_REQ-1:0] seen;
  logic             err_c;

  // More than one bit flipping between consecutive words breaks Gray adjacency.
  assign err_c = seen[win_idx] &&
                 (popcount(MAX_W'(hist[win_idx] ^ sel_gray_c)) > CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen    <= '0;
      out_err <= 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) hist[i] <= '0;
    end else if (win_any) begin
      out_err        <= err_c;
      hist[win_idx]  <= sel_gray_c;
      seen[win_idx]  <= 1'b1;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule
